// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the main decoder.
// Holds the NOP encoding, the fetch FSM state encoding, the default reset PC and the major opcodes.
package riscv_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC generation: sequential pc+4 or an aligned taken-branch target.
// Purely combinational; all arithmetic wraps modulo 2^XLEN.
module fetch_pc_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    assign pc_plus4 = instr_pc + XLEN'(4);

    // Low target bits are cleared rather than trapped on.
    assign next_pc  = PCSrc ? (PCTarget & ~XLEN'(3)) : pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads imem over req/ack, holds one instruction for decode (FETCH_PERF_CNT_EN adds counters).
// Latency: ack in cycle N -> instr_valid in N+1; accept -> next imem_req one cycle later (1 instr / 2 cycles peak).
// Backpressure: instr_ready low holds instr/instr_pc stable and keeps imem_req low until accept.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] next_pc;
    logic            capture;
    logic            accept;

    fetch_pc_gen #(
        .XLEN(XLEN)
    ) u_pc_gen (
        .instr_pc (instr_pc),
        .PCSrc    (PCSrc),
        .PCTarget (PCTarget),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = FULL;
            end
            FULL: begin
                instr_valid = 1'b1;
                if (instr_ready) state_nxt = FETCH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ack only counts while requesting, so stray acks in IDLE/FULL are dropped.
    assign capture   = imem_req & imem_ack;
    assign accept    = instr_valid & instr_ready;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            instr    <= NOP_INSTR;
            instr_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= fetch_pc;
            end
            if (accept) begin
                fetch_pc <= next_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt    <= 32'd0;
            redirect_cnt <= 32'd0;
        end else if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            if (PCSrc) redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder pushes every returned word to a scoreboard,
// which is popped and checked when decode accepts; a second instance covers the PC wrap.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC0 = 32'h0000_0000;
    localparam logic [31:0] RESET_PC1 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0, PCSrc = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0, instr, instr_pc, pc_plus4, PCTarget = 32'd0;
    logic        imem_req_w, imem_ack_w = 1'b0, instr_valid_w, instr_ready_w = 1'b0, PCSrc_w = 1'b0;
    logic [31:0] imem_addr_w, imem_rdata_w = 32'd0, instr_w, instr_pc_w, pc_plus4_w, PCTarget_w = 32'd0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, redirect_cnt, fetch_cnt_w, redirect_cnt_w;
`endif

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .PCSrc(PCSrc), .PCTarget(PCTarget)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC1)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .instr(instr_w), .instr_pc(instr_pc_w),
        .pc_plus4(pc_plus4_w), .PCSrc(PCSrc_w), .PCTarget(PCTarget_w)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt_w), .redirect_cnt(redirect_cnt_w)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          ack_delay = 1;
    logic        force_ack = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic        req_prev = 1'b0, valid_prev = 1'b0;
    logic        check_next = 1'b1, next_from_acc = 1'b0;
    logic [31:0] exp_next = RESET_PC0;
    logic [31:0] req_addr = 32'd0, held_instr = 32'd0, held_pc = 32'd0;
    int          wait_cnt = 0, last_req_len = 0, ack_cyc = -10, acc_cyc = -10, acc_cnt = 0, red_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
    endfunction

    // One cycle: inspect DUT at the negedge, drive memory response, then advance.
    task automatic tick();
        logic [63:0] e;
        if (rst) begin
            imem_ack   = force_ack;
            imem_rdata = 32'hDEAD_BEEF;
            exp_q.delete();
            req_prev = 1'b0; valid_prev = 1'b0;
            check_next = 1'b1; next_from_acc = 1'b0; exp_next = RESET_PC0;
            acc_cnt = 0; red_cnt = 0;
        end else begin
            n_tests++;
            if ((imem_req & instr_valid) !== 1'b0) begin
                n_fail++;
                $display("FAIL req_valid_excl cyc=%0d: req=%b valid=%b, required not both high", cyc, imem_req, instr_valid);
            end
            if (imem_req === 1'b1) begin
                if (!req_prev) begin
                    req_addr = imem_addr; wait_cnt = 0;
                    addr_log.push_back(imem_addr);
                    if (check_next) begin
                        n_tests++;
                        if (imem_addr !== exp_next) begin
                            n_fail++;
                            $display("FAIL next_addr cyc=%0d: got %h, required %h", cyc, imem_addr, exp_next);
                        end
                        check_next = 1'b0;
                    end
                    if (next_from_acc) begin
                        n_tests++;
                        if (cyc !== acc_cyc + 1) begin
                            n_fail++;
                            $display("FAIL req_after_accept: req at cyc %0d, required %0d", cyc, acc_cyc + 1);
                        end
                        next_from_acc = 1'b0;
                    end
                end else begin
                    wait_cnt++;
                    n_tests++;
                    if (imem_addr !== req_addr) begin
                        n_fail++;
                        $display("FAIL addr_held cyc=%0d: got %h, required %h", cyc, imem_addr, req_addr);
                    end
                end
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    exp_q.push_back({imem_addr, imem_rdata});
                    ack_cyc = cyc; last_req_len = wait_cnt + 1;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            req_prev = (imem_req === 1'b1);

            if (instr_valid === 1'b1) begin
                n_tests++;
                if (!valid_prev) begin
                    if (cyc !== ack_cyc + 1) begin
                        n_fail++;
                        $display("FAIL valid_latency: valid at cyc %0d, required %0d", cyc, ack_cyc + 1);
                    end
                    held_instr = instr; held_pc = instr_pc;
                end else if (instr !== held_instr || instr_pc !== held_pc) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc=%0d: got %h@%h, required %h@%h", cyc, instr, instr_pc, held_instr, held_pc);
                end
                if (instr_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL accept_data cyc=%0d: got %h@%h, required nothing pending", cyc, instr, instr_pc);
                        e = {instr_pc, instr};
                    end else begin
                        e = exp_q.pop_front();
                        if ({instr_pc, instr} !== e || pc_plus4 !== e[63:32] + 32'd4) begin
                            n_fail++;
                            $display("FAIL accept_data cyc=%0d: got %h@%h p4=%h, required %h@%h p4=%h",
                                     cyc, instr, instr_pc, pc_plus4, e[31:0], e[63:32], e[63:32] + 32'd4);
                        end
                    end
                    exp_next = PCSrc ? {PCTarget[31:2], 2'b00} : e[63:32] + 32'd4;
                    check_next = 1'b1; next_from_acc = 1'b1; acc_cyc = cyc;
                    acc_cnt++;
                    if (PCSrc) red_cnt++;
                end
            end
            valid_prev = (instr_valid === 1'b1) && !instr_ready;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_accepts(input int n, input string name);
        int target = acc_cnt + n;
        int k = 0;
        while (acc_cnt < target && k < 200) begin tick(); k++; end
        n_tests++;
        if (acc_cnt < target) begin
            n_fail++;
            $display("FAIL %s_timeout: accepts=%0d, required %0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_req(input string name);
        int sz = addr_log.size();
        int k = 0;
        while (addr_log.size() == sz && k < 50) begin tick(); k++; end
        n_tests++;
        if (addr_log.size() == sz) begin
            n_fail++;
            $display("FAIL %s_req_timeout: requests=%0d, required %0d", name, addr_log.size(), sz + 1);
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (imem_req_w !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_tests++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== RESET_PC1) begin
            n_fail++;
            $display("FAIL wrap_first_req: req=%b addr=%h, required 1 %h", imem_req_w, imem_addr_w, RESET_PC1);
        end
        imem_ack_w = 1'b1; imem_rdata_w = 32'h00A0_0093;
        @(negedge clk);
        imem_ack_w = 1'b0;
        n_tests++;
        if (instr_valid_w !== 1'b1 || instr_w !== 32'h00A0_0093 || instr_pc_w !== RESET_PC1) begin
            n_fail++;
            $display("FAIL wrap_capture: valid=%b instr=%h pc=%h, required 1 00a00093 %h", instr_valid_w, instr_w, instr_pc_w, RESET_PC1);
        end
        n_tests++;
        if (pc_plus4_w !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc_plus4: got %h, required 00000000", pc_plus4_w);
        end
        instr_ready_w = 1'b1; PCSrc_w = 1'b0; PCTarget_w = 32'h1234_5678;
        @(negedge clk);
        instr_ready_w = 1'b0;
        n_tests++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_next_addr: req=%b addr=%h, required 1 00000000", imem_req_w, imem_addr_w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b0; PCSrc = 1'b0;
        tick();
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b valid=%b addr=%h, required 0 0 %h", imem_req, instr_valid, imem_addr, RESET_PC0);
        end
        n_tests++;
        if (instr !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL reset_instr: got %h, required 00000013", instr);
        end
        n_tests++;
        if (instr_pc !== RESET_PC0 || pc_plus4 !== RESET_PC0 + 32'd4) begin
            n_fail++;
            $display("FAIL reset_pc: pc=%h p4=%h, required %h %h", instr_pc, pc_plus4, RESET_PC0, RESET_PC0 + 32'd4);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        instr_ready = 1'b1; ack_delay = 1;
        addr_log.delete();
        run_accepts(4, "seq");
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (addr_log[i] !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h, required %h", i, addr_log[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_ack_delay();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        instr_ready = 1'b1; ack_delay = 1;
        run_accepts(2, "delay_pre");
        ack_delay = 3;
        addr_log.delete();
        run_accepts(1, "delay");
        ack_delay = 1;
        n_tests++;
        if (addr_log[0] !== 32'h8 || last_req_len !== 4) begin
            n_fail++;
            $display("FAIL delay_req: addr=%h held %0d cycles, required 00000008 held 4", addr_log[0], last_req_len);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        logic [31:0] s_instr, s_pc;
        instr_ready = 1'b0;
        while (instr_valid !== 1'b1 && k < 20) begin tick(); k++; end
        s_instr = instr; s_pc = instr_pc;
        repeat (5) tick();
        n_tests++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== s_instr || instr_pc !== s_pc) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b req=%b %h@%h, required 1 0 %h@%h", instr_valid, imem_req, instr, instr_pc, s_instr, s_pc);
        end
        instr_ready = 1'b1;
        addr_log.delete();
        run_accepts(1, "stall");
        wait_req("stall");
        n_tests++;
        if (addr_log[0] !== s_pc + 32'd4) begin
            n_fail++;
            $display("FAIL stall_next: got %h, required %h", addr_log[0], s_pc + 32'd4);
        end
    endtask

    task automatic test_branch();
        instr_ready = 1'b1;
        PCSrc = 1'b1; PCTarget = 32'h0000_0103;
        run_accepts(1, "branch");
        PCSrc = 1'b0; PCTarget = $urandom;
        addr_log.delete();
        wait_req("branch");
        n_tests++;
        if (addr_log[0] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL branch_target: got %h, required 00000100", addr_log[0]);
        end
        run_accepts(1, "fallthru");
        wait_req("fallthru");
        n_tests++;
        if (addr_log[1] !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL branch_fallthru: got %h, required 00000104", addr_log[1]);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        instr_ready = 1'b1; ack_delay = 5;
        while (imem_req !== 1'b1 && k < 20) begin tick(); k++; end
        tick();
        rst = 1'b1; force_ack = 1'b1;
        tick();
        rst = 1'b0; force_ack = 1'b0; ack_delay = 1;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: valid=%b req=%b, required 0 0", instr_valid, imem_req);
        end
        addr_log.delete();
        wait_req("midreset");
        n_tests++;
        if (addr_log[0] !== RESET_PC0) begin
            n_fail++;
            $display("FAIL midreset_addr: got %h, required %h", addr_log[0], RESET_PC0);
        end
    endtask

    task automatic test_counters();
        instr_ready = 1'b1;
        PCSrc = 1'b0; run_accepts(1, "cnt0");
        PCSrc = 1'b1; PCTarget = 32'h0000_0040; run_accepts(1, "cnt1");
        PCSrc = 1'b0; run_accepts(1, "cnt2");
        tick();
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (fetch_cnt !== 32'd3 || redirect_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_cnt: fetch=%0d redirect=%0d, required 3 1", fetch_cnt, redirect_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_wrap();
        test_reset();
        test_sequential();
        test_ack_delay();
        test_stall();
        test_branch();
        test_reset_mid();
        test_counters();
        instr_ready = 1'b0;
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
